// File: rtl/baser_pkg.sv
// Shared constants and types for the 10GBASE-R 64b/66b transmit path.
package baser_pkg;

  // Sync headers
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Block type field values
  localparam logic [7:0] BT_C   = 8'h1E;
  localparam logic [7:0] BT_OS0 = 8'h4B;
  localparam logic [7:0] BT_S0  = 8'h78;
  localparam logic [7:0] BT_S4  = 8'h33;
  localparam logic [7:0] BT_T0  = 8'h87;
  localparam logic [7:0] BT_T1  = 8'h99;
  localparam logic [7:0] BT_T2  = 8'hAA;
  localparam logic [7:0] BT_T3  = 8'hB4;
  localparam logic [7:0] BT_T4  = 8'hCC;
  localparam logic [7:0] BT_T5  = 8'hD2;
  localparam logic [7:0] BT_T6  = 8'hE1;
  localparam logic [7:0] BT_T7  = 8'hFF;

  // XGMII control characters
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERROR = 8'hFE;
  localparam logic [7:0] XG_SEQ   = 8'h9C;
  localparam logic [7:0] XG_LPI   = 8'h06;

  // 7-bit control codes
  localparam logic [6:0] C7_IDLE  = 7'h00;
  localparam logic [6:0] C7_LPI   = 7'h06;
  localparam logic [6:0] C7_ERROR = 7'h1E;

  // All-idle control block and the error block
  localparam logic [63:0] IDLE_BLOCK = {{8{C7_IDLE}}, BT_C};
  localparam logic [63:0] EBLOCK_T   = {{8{C7_ERROR}}, BT_C};

  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;
  typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_class_t;

  // 8b XGMII control character to 7b block code
  function automatic logic [6:0] ctrl_7b(input logic [7:0] c);
    case (c)
      XG_IDLE: return C7_IDLE;
      XG_LPI:  return C7_LPI;
      default: return C7_ERROR;
    endcase
  endfunction

  // Terminate block type for /T/ in lane k
  function automatic logic [7:0] term_type(input int unsigned k);
    case (k)
      0:       return BT_T0;
      1:       return BT_T1;
      2:       return BT_T2;
      3:       return BT_T3;
      4:       return BT_T4;
      5:       return BT_T5;
      6:       return BT_T6;
      default: return BT_T7;
    endcase
  endfunction

endpackage

// File: rtl/baser_scrambler_64.sv
// Self-synchronous 64b scrambler, G(x) = 1 + x^39 + x^58, LSB first.
// Used by xgmii_baser_enc_64 only when BASER_SCRAMBLER_EN is defined.
module baser_scrambler_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_in,
  output logic [63:0] data_out
);

  logic [57:0] state;
  logic [57:0] lfsr;

  // Combinational 64-bit step; each scrambled bit feeds back into the history
  always_comb begin
    lfsr     = state;
    data_out = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      data_out[i] = data_in[i] ^ lfsr[38] ^ lfsr[57];
      lfsr        = {lfsr[56:0], data_out[i]};
    end
  end

  // State advances once per emitted block
  always_ff @(posedge clk) begin
    if (rst) state <= '1;
    else     state <= lfsr;
  end

endmodule

// File: rtl/xgmii_baser_enc_64.sv
// 10GBASE-R PCS transmit encoder: 64-bit XGMII to 64b/66b blocks.
// Stage 1 classifies and encodes, stage 2 runs the TX sequence check.
// Define BASER_SCRAMBLER_EN to scramble the payload on the way out.
module xgmii_baser_enc_64
  import baser_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] xgmii_txd,
  input  logic [CTRL_WIDTH-1:0] xgmii_txc,
  output logic [DATA_WIDTH-1:0] encoded_tx_data,
  output logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  output logic                  tx_bad_block
);

  if (DATA_WIDTH != 64) begin : g_width_check
    $error("xgmii_baser_enc_64: only DATA_WIDTH = 64 is supported");
  end

  logic [7:0]      lane [8];
  logic [6:0]      code [8];
  logic            any_st;
  logic            term_hit;
  int unsigned     term_k;
  blk_class_t      cls;
  logic [1:0]      hdr;
  logic [63:0]     pay;

  blk_class_t      s1_cls;
  logic [1:0]      s1_hdr;
  logic [63:0]     s1_data;

  tx_state_t       state, state_nx;
  logic            bad_nx;
  logic [1:0]      hdr_nx;
  logic [63:0]     data_nx;
  logic [63:0]     data_out_nx;

  // Classify the incoming XGMII word and build its block payload
  always_comb begin
    any_st   = 1'b0;
    term_hit = 1'b0;
    term_k   = 0;
    cls      = BLK_E;
    hdr      = SYNC_CTRL;
    pay      = EBLOCK_T;
    for (int unsigned j = 0; j < 8; j++) begin
      lane[j] = xgmii_txd[8*j +: 8];
      code[j] = ctrl_7b(lane[j]);
      if (xgmii_txc[j] && (lane[j] == XG_START || lane[j] == XG_TERM)) any_st = 1'b1;
      if (!term_hit && xgmii_txc[j] && lane[j] == XG_TERM) begin
        term_hit = 1'b1;
        term_k   = j;
      end
    end

    if (xgmii_txc == '0) begin
      cls = BLK_D;
      hdr = SYNC_DATA;
      pay = xgmii_txd;
    end else if (xgmii_txc == '1 && !any_st) begin
      cls = BLK_C;
      pay = {56'h0, BT_C};
      for (int unsigned j = 0; j < 8; j++) pay[8+7*j +: 7] = code[j];
    end else if (xgmii_txc == 8'hF1 && lane[0] == XG_SEQ && lane[4] == XG_IDLE &&
                 lane[5] == XG_IDLE && lane[6] == XG_IDLE && lane[7] == XG_IDLE) begin
      cls = BLK_C;
      pay = {28'h0, 4'h0, xgmii_txd[31:8], BT_OS0};
    end else if (xgmii_txc == 8'h01 && lane[0] == XG_START) begin
      cls = BLK_S;
      pay = {xgmii_txd[63:8], BT_S0};
    end else if (xgmii_txc == 8'h1F && lane[4] == XG_START) begin
      cls = BLK_S;
      pay = {xgmii_txd[63:40], 4'h0, code[3], code[2], code[1], code[0], BT_S4};
    end else if (term_hit && xgmii_txc == (8'hFF << term_k)) begin
      // Data lanes sit on byte boundaries after the type field; codes for the
      // lanes after /T/ pack from the top, leaving 7-k pad bits in between.
      cls = BLK_T;
      pay = {56'h0, term_type(term_k)};
      for (int unsigned j = 0; j < 8; j++) begin
        if (j < term_k)      pay[8+8*j +: 8] = lane[j];
        else if (j > term_k) pay[8+7*j +: 7] = code[j];
      end
    end
  end

  // Stage 1 register: encoded block and its class
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_cls  <= BLK_C;
      s1_hdr  <= SYNC_CTRL;
      s1_data <= IDLE_BLOCK;
    end else begin
      s1_cls  <= cls;
      s1_hdr  <= hdr;
      s1_data <= pay;
    end
  end

  // TX sequence check: next state and error-block substitution
  always_comb begin
    state_nx = TX_E;
    case (state)
      TX_INIT, TX_C, TX_T: begin
        if (s1_cls == BLK_C)      state_nx = TX_C;
        else if (s1_cls == BLK_S) state_nx = TX_D;
      end
      TX_D: begin
        if (s1_cls == BLK_D)      state_nx = TX_D;
        else if (s1_cls == BLK_T) state_nx = TX_T;
      end
      TX_E: begin
        if (s1_cls == BLK_D)      state_nx = TX_D;
        else if (s1_cls == BLK_C) state_nx = TX_C;
        else if (s1_cls == BLK_T) state_nx = TX_T;
      end
      default: state_nx = TX_E;
    endcase
    bad_nx  = (state_nx == TX_E);
    hdr_nx  = bad_nx ? SYNC_CTRL : s1_hdr;
    data_nx = bad_nx ? EBLOCK_T  : s1_data;
  end

`ifdef BASER_SCRAMBLER_EN
  baser_scrambler_64 u_scrambler (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_nx),
    .data_out (data_out_nx)
  );
`else
  assign data_out_nx = data_nx;
`endif

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) state <= TX_INIT;
    else     state <= state_nx;
  end

  // Stage 2 output register
  always_ff @(posedge clk) begin
    if (rst) begin
      encoded_tx_hdr  <= SYNC_CTRL;
      encoded_tx_data <= IDLE_BLOCK;
      tx_bad_block    <= 1'b0;
    end else begin
      encoded_tx_hdr  <= hdr_nx;
      encoded_tx_data <= data_out_nx;
      tx_bad_block    <= bad_nx;
    end
  end

endmodule

// File: tb/tb_xgmii_baser_enc_64.sv
// Directed and random-frame bench for xgmii_baser_enc_64 with a scoreboard queue.
// With BASER_SCRAMBLER_EN defined the DUT payload is descrambled before comparing.
module tb_xgmii_baser_enc_64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] txd = 64'h0707070707070707;
  logic [7:0]  txc = 8'hFF;
  logic [63:0] enc_data;
  logic [1:0]  enc_hdr;
  logic        bad;

  xgmii_baser_enc_64 #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .HDR_WIDTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .xgmii_txd       (txd),
    .xgmii_txc       (txc),
    .encoded_tx_data (enc_data),
    .encoded_tx_hdr  (enc_hdr),
    .tx_bad_block    (bad)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        bad;
  } exp_t;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] EBLK   = {{8{7'h1E}}, 8'h1E};

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;
  logic [57:0] dscr   = '1;
  logic [7:0]  tt [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  function automatic exp_t blk(input string tag, input logic [1:0] h,
                               input logic [63:0] d, input logic b);
    exp_t e;
    e.tag = tag; e.hdr = h; e.data = d; e.bad = b;
    return e;
  endfunction

  task automatic compare(input string tag, input logic [1:0] oh, input logic [63:0] od,
                         input logic ob, input exp_t e);
    checks++;
    assert ({oh, od, ob} === {e.hdr, e.data, e.bad}) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed hdr=%b data=%h bad=%b expected hdr=%b data=%h bad=%b",
             tag, oh, od, ob, e.hdr, e.data, e.bad);
    end
  endtask

  task automatic check_one();
    exp_t        e;
    logic [63:0] obs;
    e   = q.pop_front();
    obs = enc_data;
`ifdef BASER_SCRAMBLER_EN
    for (int i = 0; i < 64; i++) begin
      obs[i] = enc_data[i] ^ dscr[38] ^ dscr[57];
      dscr   = {dscr[56:0], enc_data[i]};
    end
`endif
    compare(e.tag, enc_hdr, obs, bad, e);
  endtask

  // Drive one XGMII word; outputs seen now belong to the word driven two steps ago
  task automatic step(input string tag, input logic [63:0] d, input logic [7:0] c,
                      input logic [1:0] eh, input logic [63:0] ed, input logic eb);
    @(negedge clk);
    if (q.size() >= 2) check_one();
    rst = 1'b0;
    txd = d;
    txc = c;
    q.push_back(blk(tag, eh, ed, eb));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    if (q.size() >= 2) check_one();
    rst = 1'b1;
    txd = IDLE_W;
    txc = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    compare(tag, enc_hdr, enc_data, bad, blk(tag, 2'b10, 64'h1E, 1'b0));
    q.delete();
    q.push_back(blk({tag, "_flush"}, 2'b10, 64'h1E, 1'b0));
    dscr = '1;
  endtask

  task automatic idle(input string tag);
    step(tag, IDLE_W, 8'hFF, 2'b10, 64'h1E, 1'b0);
  endtask

  // Terminate word with /T/ in lane k, data below, idles above
  task automatic term(input string tag, input logic [63:0] base, input int k);
    logic [63:0] d;
    logic [63:0] mask;
    d = base;
    for (int j = k; j < 8; j++) d[8*j +: 8] = (j == k) ? 8'hFD : 8'h07;
    mask = (64'h1 << (8*k)) - 64'h1;
    step(tag, d, 8'hFF << k, 2'b10, ((base & mask) << 8) | {56'h0, tt[k]}, 1'b0);
  endtask

  initial begin
    logic [63:0] r;
    int          nd;

    // Reset and idle stream
    do_reset("reset");
    idle("idle0");
    idle("idle1");

    // Basic frame
    step("frame_s", 64'hD5555555555555FB, 8'h01, 2'b10, 64'hD555555555555578, 1'b0);
    step("frame_d0", 64'h1122334455667788, 8'h00, 2'b01, 64'h1122334455667788, 1'b0);
    step("frame_d1", 64'h99AABBCCDDEEFF00, 8'h00, 2'b01, 64'h99AABBCCDDEEFF00, 1'b0);
    step("frame_d2", 64'h0123456789ABCDEF, 8'h00, 2'b01, 64'h0123456789ABCDEF, 1'b0);
    step("frame_t", 64'h07070707070707FD, 8'hFF, 2'b10, 64'h87, 1'b0);

    // All eight terminate positions, each right after a start (T,S back to back)
    for (int k = 0; k < 8; k++) begin
      step("tk_s", 64'h55555555555555FB, 8'h01, 2'b10, 64'h5555555555555578, 1'b0);
      term("tk_t", 64'h4746454443424140, k);
    end

    // Sequence errors and recovery
    idle("seq_c");
    step("seq_s1", 64'hD5555555555555FB, 8'h01, 2'b10, 64'hD555555555555578, 1'b0);
    step("seq_s2", 64'hD5555555555555FB, 8'h01, 2'b10, EBLK, 1'b1);
    step("seq_d_after_e", 64'hCAFEBABE12345678, 8'h00, 2'b01, 64'hCAFEBABE12345678, 1'b0);
    term("seq_t", 64'h0, 0);
    idle("seq_c2");
    step("seq_c_then_d", 64'h0000000000000001, 8'h00, 2'b10, EBLK, 1'b1);
    idle("seq_e_to_c");

    // Other control block forms
    step("os_4b", 64'h070707073322119C, 8'hF1, 2'b10, 64'h000000003322114B, 1'b0);
    step("c_err", 64'h07070707070707FE, 8'hFF, 2'b10, 64'h0000000000001E1E, 1'b0);
    step("c_lpi", 64'h0707070707070706, 8'hFF, 2'b10, 64'h000000000000061E, 1'b0);
    step("s_lane4", 64'hCCBBAAFB07070707, 8'h1F, 2'b10, 64'hCCBBAA0000000033, 1'b0);
    step("s4_d", 64'h0F0E0D0C0B0A0908, 8'h00, 2'b01, 64'h0F0E0D0C0B0A0908, 1'b0);
    term("s4_t", 64'h0, 0);
    idle("os4_pre");
    step("os_lane4_e", 64'hDDEEFF9C07070707, 8'h1F, 2'b10, EBLK, 1'b1);
    idle("os4_post");
    term("t_after_c", 64'h0, 0);
    q[q.size()-1] = blk("t_after_c", 2'b10, EBLK, 1'b1);
    idle("t_after_c_rec");

    // Reset mid-frame, then data without a start
    step("mid_s", 64'hD5555555555555FB, 8'h01, 2'b10, 64'hD555555555555578, 1'b0);
    step("mid_d", 64'hAAAAAAAAAAAAAAAA, 8'h00, 2'b01, 64'hAAAAAAAAAAAAAAAA, 1'b0);
    do_reset("mid_reset");
    step("d_no_s", 64'h1234123412341234, 8'h00, 2'b10, EBLK, 1'b1);
    idle("post_reset_c");

    // Random legal frames
    for (int f = 0; f < 24; f++) begin
      r = {$urandom, $urandom};
      r[7:0] = 8'hFB;
      step("rnd_s", r, 8'h01, 2'b10, {r[63:8], 8'h78}, 1'b0);
      nd = int'($urandom_range(0, 3));
      for (int i = 0; i < nd; i++) begin
        r = {$urandom, $urandom};
        step("rnd_d", r, 8'h00, 2'b01, r, 1'b0);
      end
      term("rnd_t", {$urandom, $urandom}, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) idle("rnd_c");
    end

    // Drain the pipeline
    idle("drain0");
    idle("drain1");
    idle("drain2");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
